// File: rtl/bullet_scheduler.sv
`timescale 1ns/1ps
// bullet_scheduler: turns the fire button into one-hot launch commands for a
// pool of bullet slots. Slots are picked round-robin among free ones, each
// launch is held until the slot acknowledges by going busy, and accepted
// launches are spaced by a frame-counted cooldown.
module bullet_scheduler #(
  parameter int NUM_BULLETS        = 4,
  parameter int COOLDOWN_FRAMES    = 8,
  parameter int ACK_TIMEOUT_FRAMES = 2,
  parameter int AUTO_FIRE          = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fire,
  input  logic                   frame,
  input  logic [NUM_BULLETS-1:0] slot_busy,
  output logic [NUM_BULLETS-1:0] fire_slot,
  output logic [3:0]             active_count,
  output logic [15:0]            shots_fired,
  output logic                   dropped,
  output logic                   ack_error,
  output logic [1:0]             sched_state
);

  localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int TW = (ACK_TIMEOUT_FRAMES > 0) ? $clog2(ACK_TIMEOUT_FRAMES + 1) : 1;
  localparam logic AUTO_FIRE_EN = (AUTO_FIRE != 0);
  localparam logic [NUM_BULLETS-1:0] ONE_HOT0 = {{(NUM_BULLETS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ISSUE      = 2'd2,
    ST_COOLDOWN   = 2'd3
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   sel_r;
  logic            pending_r;
  logic            fire_q_r;
  logic [CW-1:0]   cd_cnt_r;
  logic [TW-1:0]   to_cnt_r;

  logic            rise_s;
  logic            request_s;
  logic            ack_s;
  logic            found_s;
  logic [IW-1:0]   free_idx_s;
  logic [3:0]      cand_s;
  logic [IW-1:0]   next_rr_s;

  // Count of set bits in the busy vector.
  function automatic logic [3:0] popcount(input logic [NUM_BULLETS-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  assign rise_s      = fire & ~fire_q_r;
  assign request_s   = (rise_s | pending_r | (AUTO_FIRE_EN & fire)) & enable;
  assign ack_s       = slot_busy[sel_r];
  assign sched_state = state_r;

  // First free slot searching upward from the round-robin pointer, wrapping.
  always_comb begin
    found_s    = 1'b0;
    free_idx_s = '0;
    cand_s     = 4'd0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      cand_s = 4'(rr_ptr_r) + 4'(i);
      if (cand_s >= 4'(NUM_BULLETS)) begin
        cand_s = cand_s - 4'(NUM_BULLETS);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && !slot_busy[cand_s[IW-1:0]]) begin
        found_s    = 1'b1;
        free_idx_s = cand_s[IW-1:0];
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Pointer value following the slot that was just acknowledged.
  always_comb begin
    if (sel_r == IW'(NUM_BULLETS - 1)) begin
      next_rr_s = '0;
    end else begin
      next_rr_s = sel_r + IW'(1);
    end
  end

  // Fire level history for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_q_r <= 1'b0;
    end else begin
      fire_q_r <= fire;
    end
  end

  // Occupancy count, one cycle behind slot_busy, independent of the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_count <= 4'd0;
    end else begin
      active_count <= popcount(slot_busy);
    end
  end

  // Launch FSM with its registered outputs and bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      sel_r       <= '0;
      pending_r   <= 1'b0;
      cd_cnt_r    <= '0;
      to_cnt_r    <= '0;
      fire_slot   <= '0;
      shots_fired <= 16'd0;
      dropped     <= 1'b0;
      ack_error   <= 1'b0;
    end else begin
      dropped <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (request_s) begin
            state_r   <= ST_WAIT_FRAME;
            pending_r <= 1'b0;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_WAIT_FRAME: begin
          if (rise_s) begin
            pending_r <= 1'b1;
          end else begin
            pending_r <= pending_r;
          end
          if (!enable) begin
            state_r <= ST_IDLE;
          end else if (frame) begin
            if (found_s) begin
              fire_slot <= ONE_HOT0 << free_idx_s;
              sel_r     <= free_idx_s;
              to_cnt_r  <= '0;
              state_r   <= ST_ISSUE;
            end else begin
              dropped   <= 1'b1;
              state_r   <= ST_IDLE;
            end
          end else begin
            state_r <= ST_WAIT_FRAME;
          end
        end
        ST_ISSUE: begin
          if (rise_s) begin
            pending_r <= 1'b1;
          end else begin
            pending_r <= pending_r;
          end
          // Acknowledge takes priority over a timeout on the same cycle.
          if (ack_s) begin
            fire_slot <= '0;
            rr_ptr_r  <= next_rr_s;
            cd_cnt_r  <= CW'(COOLDOWN_FRAMES);
            state_r   <= ST_COOLDOWN;
            if (shots_fired != 16'hFFFF) begin
              shots_fired <= shots_fired + 16'd1;
            end else begin
              shots_fired <= shots_fired;
            end
          end else if (frame) begin
            if ((int'(to_cnt_r) + 32'sd1) >= ACK_TIMEOUT_FRAMES) begin
              fire_slot <= '0;
              ack_error <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              to_cnt_r  <= to_cnt_r + TW'(1);
            end
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_COOLDOWN: begin
          if (rise_s) begin
            pending_r <= 1'b1;
          end else begin
            pending_r <= pending_r;
          end
          if (cd_cnt_r == '0) begin
            state_r <= ST_IDLE;
          end else if (frame) begin
            cd_cnt_r <= cd_cnt_r - CW'(1);
          end else begin
            state_r <= ST_COOLDOWN;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          fire_slot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for bullet_scheduler: directed table of launches,
// hand-written multi-cycle sequences and a randomized scoreboard run.
module tb_bullet_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         fire;
  logic         frame;
  logic [N-1:0] slot_busy;
  logic [N-1:0] fire_slot;
  logic [3:0]   active_count;
  logic [15:0]  shots_fired;
  logic         dropped;
  logic         ack_error;
  logic [1:0]   sched_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  bullet_scheduler #(
    .NUM_BULLETS(N), .COOLDOWN_FRAMES(8), .ACK_TIMEOUT_FRAMES(2), .AUTO_FIRE(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fire(fire), .frame(frame),
    .slot_busy(slot_busy), .fire_slot(fire_slot), .active_count(active_count),
    .shots_fired(shots_fired), .dropped(dropped), .ack_error(ack_error),
    .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] busy;
    logic [3:0] exp_fire;
    logic       exp_drop;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    tick();
    fire = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    for (int i = 0; i < 200 && sched_state !== s; i++) tick();
    check(name, sched_state, s);
  endtask

  // Strobe frames until the scheduler is back in IDLE.
  task automatic drain();
    for (int i = 0; i < 40 && sched_state !== 2'd0; i++) begin
      pulse_frame();
      tick();
    end
    check("drain_idle", sched_state, 2'd0);
  endtask

  // Reference slot choice: first free index upward from rr, wrapping.
  function automatic logic [3:0] pick(input logic [3:0] busy, input int rr);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (rr + i) % N;
      if (!busy[j]) return 4'b0001 << j;
    end
    return 4'b0000;
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int exp_shots;
    int n_high;
    int lf[$];
    logic [3:0] ls[$];
    logic [3:0] prev_fs;
    int life[N];

    tbl[0] = '{4'b0000, 4'b0010, 1'b0};
    tbl[1] = '{4'b0100, 4'b1000, 1'b0};
    tbl[2] = '{4'b0001, 4'b0010, 1'b0};
    tbl[3] = '{4'b1100, 4'b0001, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 1'b1};
    tbl[5] = '{4'b0011, 4'b0100, 1'b0};
    tbl[6] = '{4'b1011, 4'b0100, 1'b0};
    tbl[7] = '{4'b0111, 4'b1000, 1'b0};
    tbl[8] = '{4'b1110, 4'b0001, 1'b0};

    rst = 1'b0; enable = 1'b1; fire = 1'b0; frame = 1'b0; slot_busy = 4'b0000;
    tick();
    // Reset state
    check("rst_fire_slot", fire_slot, 4'b0000);
    check("rst_active", active_count, 4'd0);
    check("rst_shots", shots_fired, 16'd0);
    check("rst_dropped", dropped, 1'b0);
    check("rst_ack_error", ack_error, 1'b0);
    check("rst_state", sched_state, 2'd0);
    do_reset();

    // Launch held until slot 0 acknowledges on the third cycle.
    pulse_fire();
    check("a_wait", sched_state, 2'd1);
    pulse_frame();
    check("a_fire", fire_slot, 4'b0001);
    n_high = 0;
    for (int g = 0; g < 20 && fire_slot != 4'b0000; g++) begin
      n_high++;
      if (n_high == 3) slot_busy = 4'b0001;
      tick();
    end
    check("a_held_cycles", n_high, 3);
    check("a_shots", shots_fired, 16'd1);
    check("a_state", sched_state, 2'd3);
    exp_shots = 1;
    slot_busy = 4'b0000;
    drain();

    // Table of round-robin launches, starting with rr_ptr=1.
    for (int v = 0; v < 9; v++) begin
      wait_state(2'd0, "tbl_idle");
      slot_busy = tbl[v].busy;
      pulse_fire();
      wait_state(2'd1, "tbl_wait");
      pulse_frame();
      check("tbl_fire", fire_slot, tbl[v].exp_fire);
      check("tbl_drop", dropped, tbl[v].exp_drop);
      if (tbl[v].exp_drop) begin
        check("tbl_drop_state", sched_state, 2'd0);
        check("tbl_drop_shots", shots_fired, exp_shots);
        tick();
        check("tbl_drop_pulse", dropped, 1'b0);
      end else begin
        slot_busy = tbl[v].busy | tbl[v].exp_fire;
        tick();
        exp_shots++;
        check("tbl_ack_clear", fire_slot, 4'b0000);
        check("tbl_ack_shots", shots_fired, exp_shots);
        check("tbl_ack_state", sched_state, 2'd3);
        slot_busy = 4'b0000;
        drain();
      end
    end

    // Auto-fire spacing with immediate acknowledge.
    do_reset();
    fire = 1'b1;
    prev_fs = 4'b0000;
    for (int k = 0; k < N; k++) life[k] = 0;
    for (int f = 0; f < 60 && lf.size() < 5; f++) begin
      for (int c = 0; c < 6; c++) begin
        frame = (c == 0);
        tick();
        frame = 1'b0;
        if (fire_slot != 4'b0000 && prev_fs == 4'b0000) begin
          lf.push_back(f);
          ls.push_back(fire_slot);
        end
        prev_fs = fire_slot;
        for (int k = 0; k < N; k++) begin
          if (fire_slot[k]) begin
            slot_busy[k] = 1'b1;
            life[k] = 3;
          end else if (life[k] > 0) begin
            life[k]--;
            if (life[k] == 0) slot_busy[k] = 1'b0;
          end
        end
      end
    end
    check("af_launches", lf.size(), 5);
    for (int i = 0; i < lf.size(); i++) begin
      check("af_slot", ls[i], 4'b0001 << (i % N));
      if (i > 0) check("af_spacing", lf[i] - lf[i-1], 9);
    end
    fire = 1'b0;
    tick();
    check("af_shots", shots_fired, 16'd5);
    slot_busy = 4'b0000;
    drain();

    // Launch that is never acknowledged times out after two strobes.
    pulse_fire();
    wait_state(2'd1, "to_wait");
    pulse_frame();
    check("to_fire", fire_slot, 4'b0010);
    tick(); tick();
    pulse_frame();
    check("to_hold", fire_slot, 4'b0010);
    check("to_no_err", ack_error, 1'b0);
    tick();
    pulse_frame();
    check("to_clear", fire_slot, 4'b0000);
    check("to_err", ack_error, 1'b1);
    check("to_state", sched_state, 2'd0);
    tick();
    check("to_sticky", ack_error, 1'b1);
    pulse_fire();
    wait_state(2'd1, "to_re_wait");
    pulse_frame();
    check("to_re_fire", fire_slot, 4'b0010);
    slot_busy = 4'b0010;
    tick();
    check("to_re_shots", shots_fired, 16'd6);
    slot_busy = 4'b0000;
    // A rising edge during cooldown is remembered and launched afterwards.
    pulse_fire();
    for (int i = 0; i < 40 && sched_state !== 2'd1; i++) begin
      frame = (sched_state == 2'd3);
      tick();
      frame = 1'b0;
    end
    check("pend_wait", sched_state, 2'd1);
    pulse_frame();
    check("pend_fire", fire_slot, 4'b0100);
    slot_busy = 4'b0100;
    tick();
    check("pend_shots", shots_fired, 16'd7);
    check("pend_err_sticky", ack_error, 1'b1);
    slot_busy = 4'b0000;
    drain();

    // Asynchronous reset while slot 1 is being launched.
    do_reset();
    pulse_fire();
    wait_state(2'd1, "ar_wait0");
    pulse_frame();
    slot_busy = 4'b0001;
    tick();
    slot_busy = 4'b0000;
    drain();
    pulse_fire();
    wait_state(2'd1, "ar_wait1");
    pulse_frame();
    check("ar_fire", fire_slot, 4'b0010);
    check("ar_shots_pre", shots_fired, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_fire_clr", fire_slot, 4'b0000);
    check("ar_shots_clr", shots_fired, 16'd0);
    check("ar_state_clr", sched_state, 2'd0);
    tick();
    rst = 1'b1;
    slot_busy = 4'b0101;
    tick();
    check("ar_active1", active_count, 4'd2);
    slot_busy = 4'b1111;
    #1;
    check("ar_active_lat", active_count, 4'd2);
    tick();
    check("ar_active2", active_count, 4'd4);

    // Randomized run against a transaction-level scoreboard.
    begin : rnd
      int m_shots, m_rr, m_to;
      logic m_err;
      logic [3:0] p_busy, p_fs, exp_pick;
      logic p_frame, p_enable, exp_launch, exp_drop, acked;
      logic [1:0] p_state;
      slot_busy = 4'b0000;
      fire = 1'b0;
      do_reset();
      m_shots = 0; m_rr = 0; m_to = 0; m_err = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        enable = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 3) == 0) fire = ~fire;
        frame = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < N; k++) begin
          if (fire_slot[k]) begin
            if ($urandom_range(0, 2) != 0) slot_busy[k] = 1'b1;
          end else if ($urandom_range(0, 7) == 0) begin
            slot_busy[k] = ~slot_busy[k];
          end
        end
        p_busy = slot_busy; p_fs = fire_slot; p_frame = frame;
        p_enable = enable; p_state = sched_state;
        tick();
        check("r_active", active_count, $countones(p_busy));
        check("r_onehot", $onehot0(fire_slot), 1'b1);
        check("r_fs_issue", (fire_slot == 4'b0000) || (sched_state == 2'd2), 1'b1);
        acked = (p_fs != 4'b0000) && ((p_fs & p_busy) != 4'b0000);
        if (acked) begin
          if (m_shots < 65535) m_shots++;
          m_rr = (idx_of(p_fs) + 1) % N;
          m_to = 0;
          check("r_ack_clear", fire_slot, 4'b0000);
          check("r_ack_state", sched_state, 2'd3);
        end else if (p_fs != 4'b0000) begin
          if (p_frame) m_to++;
          if (m_to >= 2) begin
            m_err = 1'b1;
            m_to = 0;
            check("r_to_clear", fire_slot, 4'b0000);
            check("r_to_state", sched_state, 2'd0);
          end else begin
            check("r_hold", fire_slot, p_fs);
          end
        end
        exp_launch = (p_state == 2'd1) && p_frame && p_enable && (p_busy != 4'b1111);
        exp_drop = (p_state == 2'd1) && p_frame && p_enable && (p_busy == 4'b1111);
        check("r_launch", (fire_slot != 4'b0000) && (p_fs == 4'b0000), exp_launch);
        if (exp_launch) begin
          exp_pick = pick(p_busy, m_rr);
          check("r_pick", fire_slot, exp_pick);
          m_to = 0;
        end
        check("r_drop", dropped, exp_drop);
        check("r_shots", shots_fired, m_shots);
        check("r_ack_err", ack_error, m_err);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
